// File: rtl/cordic_phase_diff.sv
// cordic_phase_diff: wrapped phase step between successive CORDIC angles, with squelch,
// frame averaging and gap-driven re-priming.
module cordic_phase_diff #(
    parameter int ANGLE_HALF = 11796480,
    parameter int SQUELCH    = 65536,
    parameter int AVG_LOG2   = 4,
    parameter int GAP_MAX    = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] amplitude,
    input  logic signed [31:0] angle,
    input  logic               pre_vaild,
    output logic signed [31:0] freq,
    output logic               freq_vaild,
    output logic               squelch,
    output logic signed [31:0] avg_freq,
    output logic               avg_vaild
);
    localparam int GW = $clog2(GAP_MAX + 1);
    localparam logic signed [33:0] H  = 34'(ANGLE_HALF);
    localparam logic signed [33:0] H2 = 34'(2 * ANGLE_HALF);
    localparam logic [GW-1:0] GAP      = GW'(GAP_MAX);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);
    typedef enum logic {PRIME, RUN} state_t;
    state_t               state;
    logic signed [31:0]   prev;
    logic signed [33:0]   d1;
    logic                 v1, sq1;
    logic signed [39:0]   acc;
    logic [AVG_LOG2-1:0]  cnt;
    logic [GW-1:0]        gap;
    logic signed [31:0]   f_wrap;
    logic signed [39:0]   acc_next;
    logic                 timeout;
    always_comb begin
        f_wrap   = d1 > H ? 32'(d1 - H2) : d1 < -H ? 32'(d1 + H2) : 32'(d1);
        acc_next = acc + 40'(freq);
        timeout  = !pre_vaild && gap == GAP_LAST;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PRIME;
            prev       <= '0;
            d1         <= '0;
            v1         <= 1'b0;
            sq1        <= 1'b0;
            freq       <= '0;
            squelch    <= 1'b0;
            freq_vaild <= 1'b0;
            acc        <= '0;
            cnt        <= '0;
            avg_freq   <= '0;
            avg_vaild  <= 1'b0;
            gap        <= '0;
        end else begin
            v1         <= pre_vaild && state == RUN;
            freq_vaild <= v1;
            avg_vaild  <= 1'b0;
            if (pre_vaild) begin
                prev  <= angle;
                gap   <= '0;
                state <= RUN;
                if (state == RUN) begin
                    d1  <= {{2{angle[31]}}, angle} - {{2{prev[31]}}, prev};
                    sq1 <= amplitude < SQUELCH;
                end
            end else if (gap != GAP) begin
                gap <= gap + GW'(1);
            end
            if (v1) begin
                freq    <= sq1 ? '0 : f_wrap;
                squelch <= sq1;
            end
            // a long idle gap drops the stored angle and the partial frame
            if (timeout) begin
                state <= PRIME;
                acc   <= '0;
                cnt   <= '0;
            end else if (freq_vaild) begin
                if (&cnt) begin
                    avg_freq  <= 32'(acc_next >>> AVG_LOG2);
                    avg_vaild <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cordic_phase_diff.sv
// tb_cordic_phase_diff: directed and random stimulus against an event-queue reference model.
module tb_cordic_phase_diff;
    localparam longint H  = 11796480;
    localparam longint SQ = 65536;
    localparam int     L  = 4;
    localparam int     N  = 1 << L;
    localparam int     G  = 64;
    localparam longint A  = 2 * 65536;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [31:0] amplitude = '0;
    logic signed [31:0] angle = '0;
    logic pre_vaild = 1'b0;
    logic signed [31:0] freq, avg_freq;
    logic freq_vaild, squelch, avg_vaild;

    cordic_phase_diff dut (
        .clk(clk), .rst(rst), .amplitude(amplitude), .angle(angle), .pre_vaild(pre_vaild),
        .freq(freq), .freq_vaild(freq_vaild), .squelch(squelch),
        .avg_freq(avg_freq), .avg_vaild(avg_vaild)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic sq; longint f; } ev_t;
    typedef struct { int due; longint a; } av_t;
    ev_t fq[$];
    av_t aq[$];
    int cyc = 0, gap = 0, cnt = 0;
    bit primed = 0;
    longint prev = 0, sum = 0;
    logic m_fv = 0, m_sq = 0, m_av = 0;
    longint m_freq = 0, m_avg = 0;

    int total = 0, bad = 0;
    int ev_cnt = 0, av_cnt = 0;
    logic signed [31:0] ev_freq = '0, av_last = '0;
    logic ev_sq = 1'b0;

    function automatic longint dg(input int x);
        return longint'(x) * 65536;
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic model(input logic r, input logic v, input longint amp, input longint ang);
        ev_t e;
        longint d;
        cyc++;
        m_fv = 0;
        m_av = 0;
        if (r) begin
            fq.delete(); aq.delete();
            primed = 0; prev = 0; gap = 0; sum = 0; cnt = 0;
            m_freq = 0; m_sq = 0; m_avg = 0;
            return;
        end
        if (fq.size() > 0 && fq[0].due == cyc) begin
            e = fq.pop_front();
            m_fv = 1; m_freq = e.f; m_sq = e.sq;
            sum += e.f;
            cnt++;
            if (cnt == N) begin
                aq.push_back(av_t'{due: cyc + 1, a: sum >>> L});
                sum = 0; cnt = 0;
            end
        end
        if (aq.size() > 0 && aq[0].due == cyc) begin
            m_av = 1;
            m_avg = aq.pop_front().a;
        end
        if (v) begin
            gap = 0;
            if (primed) begin
                d = ang - prev;
                if (d > H) d -= 2 * H;
                else if (d < -H) d += 2 * H;
                fq.push_back(ev_t'{due: cyc + 1, sq: amp < SQ, f: (amp < SQ) ? 0 : d});
            end
            primed = 1;
            prev = ang;
        end else if (gap < G) begin
            gap++;
            if (gap == G) begin
                primed = 0; sum = 0; cnt = 0;
            end
        end
    endtask

    task automatic tick(input logic r, input logic v, input longint amp, input longint ang);
        rst = r;
        pre_vaild = v;
        amplitude = amp[31:0];
        angle = ang[31:0];
        @(posedge clk);
        #1;
        model(r, v, amp, ang);
        chk("freq_vaild", freq_vaild, m_fv);
        chk("freq", freq, m_freq);
        chk("squelch", squelch, m_sq);
        chk("avg_vaild", avg_vaild, m_av);
        chk("avg_freq", avg_freq, m_avg);
        if (freq_vaild) begin ev_cnt++; ev_freq = freq; ev_sq = squelch; end
        if (avg_vaild) begin av_cnt++; av_last = avg_freq; end
        rst = 0;
        pre_vaild = 0;
    endtask

    task automatic samp(input longint amp, input longint ang);
        tick(0, 1, amp, ang);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0);
    endtask

    initial begin
        int a0, b0;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_freq", freq, 0);
        chk("rst_fv", freq_vaild, 0);
        chk("rst_avg", avg_freq, 0);

        samp(A, dg(10));
        samp(A, dg(30));
        chk("lat_early", ev_cnt, 0);
        idle(1);
        chk("lat_cnt", ev_cnt, 1);
        idle(1);
        chk("step_freq", ev_freq, 1310720);
        chk("step_sq", ev_sq, 0);

        samp(A, dg(170)); samp(A, dg(-170)); idle(2);
        chk("wrap_pos", ev_freq, 1310720);
        samp(A, dg(-170)); samp(A, dg(170)); idle(2);
        chk("wrap_neg", ev_freq, -1310720);

        samp(A, 0); samp(A, dg(180)); idle(2);
        chk("edge_pos", ev_freq, dg(180));
        samp(A, 0); idle(2);
        chk("edge_neg", ev_freq, -dg(180));
        samp(A, dg(-180)); samp(A, dg(180)); idle(2);
        chk("edge_full", ev_freq, 0);

        samp(32768, dg(50)); idle(2);
        chk("sq_freq", ev_freq, 0);
        chk("sq_flag", ev_sq, 1);
        samp(A, dg(60)); idle(2);
        chk("post_sq", ev_freq, dg(10));
        chk("post_sq_flag", ev_sq, 0);

        tick(1, 0, 0, 0);
        a0 = ev_cnt; b0 = av_cnt;
        for (int i = 0; i < 17; i++) samp(A, dg(5 * i));
        idle(3);
        chk("frame_cnt", ev_cnt - a0, 16);
        chk("frame_avg_cnt", av_cnt - b0, 1);
        chk("frame_avg", av_last, 327680);

        idle(G);
        a0 = ev_cnt;
        samp(A, dg(100)); idle(3);
        chk("gap_prime", ev_cnt, a0);
        samp(A, dg(110)); idle(G - 1);
        chk("gap_run1", ev_cnt, a0 + 1);
        chk("gap_freq1", ev_freq, dg(10));
        samp(A, dg(125)); idle(2);
        chk("gap63_cnt", ev_cnt, a0 + 2);
        chk("gap63_freq", ev_freq, dg(15));

        tick(1, 0, 0, 0);
        a0 = ev_cnt;
        for (int i = 0; i < 6; i++) samp(A, dg(7 * i));
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_mid_cnt", ev_cnt - a0, 4);
        b0 = av_cnt;
        for (int i = 0; i < 17; i++) samp(A, dg(3 * i - 20));
        idle(3);
        chk("rst_frame_cnt", av_cnt - b0, 1);
        chk("rst_frame_avg", av_last, dg(3));

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 149) == 0) idle(G - 1 + int'($urandom_range(0, 1)));
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                 longint'($urandom_range(0, 4 * 65536)) - 65536,
                 longint'($urandom_range(0, 2 * 11796480)) - H);
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cordic_phase_diff.md
CORDIC_PHASE_DIFF -- requirements
Module: cordic_phase_diff

Interface
REQ-001 SHALL have parameter ANGLE_HALF, default 11796480 (180 deg in Q16.16 degrees), the angle code for +180 deg.
REQ-002 SHALL have parameter SQUELCH, default 65536 (1.0 in Q16.16), the minimum amplitude for a valid phase step.
REQ-003 SHALL have parameter AVG_LOG2, default 4, range 1..8; the averaging frame is 2^AVG_LOG2 samples.
REQ-004 SHALL have parameter GAP_MAX, default 64, the maximum idle cycles between samples before re-priming.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 amplitude  input  32  signed Q16.16 magnitude from the upstream CORDIC amplitude/angle stage.
REQ-008 angle  input  32  signed Q16.16 degrees, range [-ANGLE_HALF, +ANGLE_HALF].
REQ-009 pre_vaild  input  1  qualifies amplitude/angle for one cycle (upstream post_vaild).
REQ-010 freq  output  32  signed wrapped phase step, Q16.16 degrees per sample.
REQ-011 freq_vaild  output  1  one-cycle strobe qualifying freq and squelch.
REQ-012 squelch  output  1  high with freq_vaild when the step was squelched.
REQ-013 avg_freq  output  32  signed mean of the last frame of freq values.
REQ-014 avg_vaild  output  1  one-cycle strobe qualifying avg_freq.

Function
REQ-015 SHALL implement a 2-state FSM: PRIME (no stored angle) and RUN (previous angle held in prev).
REQ-016 In PRIME, a pre_vaild sample SHALL load prev, move the FSM to RUN, and produce no freq_vaild.
REQ-017 In RUN, a pre_vaild sample SHALL compute d = angle - prev at 34-bit signed width and then load prev with angle.
REQ-018 Wrap rule SHALL be: if d > ANGLE_HALF then d - 2*ANGLE_HALF; if d < -ANGLE_HALF then d + 2*ANGLE_HALF; otherwise d unchanged; the result is truncated to 32 bits.
REQ-019 d = +ANGLE_HALF and d = -ANGLE_HALF SHALL pass unchanged.
REQ-020 If amplitude < SQUELCH (signed compare), freq SHALL be 0 with squelch=1, and prev SHALL still update.
REQ-021 freq_vaild SHALL assert exactly 2 cycles after the qualifying pre_vaild (stage 1 subtract, stage 2 wrap/squelch).
REQ-022 The block SHALL accept back-to-back pre_vaild every cycle with no stalls.
REQ-023 freq, squelch and avg_freq SHALL hold their last values between strobes.
REQ-024 Every freq_vaild output, squelched zeros included, SHALL be added to a 40-bit signed accumulator and counted.
REQ-025 On the 2^AVG_LOG2-th count, avg_freq SHALL equal the accumulator arithmetically shifted right by AVG_LOG2 (floor).
REQ-026 avg_vaild SHALL assert 1 cycle after that freq_vaild; the accumulator and count SHALL then clear for the next frame with no lost sample.
REQ-027 A gap counter SHALL count consecutive cycles with pre_vaild low, and clear on pre_vaild.
REQ-028 When the gap counter reaches GAP_MAX, the FSM SHALL return to PRIME and the accumulator and count SHALL clear; in-flight pipeline outputs SHALL still emit.
REQ-029 A pre_vaild arriving in the same cycle as the gap counter would reach GAP_MAX SHALL take precedence: the gap counter clears and the FSM stays in RUN.

Reset
REQ-030 rst SHALL force the FSM to PRIME and clear prev, the pipeline valids, the accumulator, the count and the gap counter.
REQ-031 rst SHALL force freq=0, squelch=0, freq_vaild=0, avg_freq=0 and avg_vaild=0 on the following edge.
REQ-032 rst asserted mid-frame SHALL suppress all pending strobes; the first sample after rst SHALL only prime.

Verification
REQ-033 Bench SHALL drive angles 10*65536 then 30*65536 with amplitude 2*65536 -> a single freq_vaild carrying freq=1310720 with squelch=0, 2 cycles after the second sample.
REQ-034 Bench SHALL drive angles 170*65536 then -170*65536 -> freq=+1310720; then drive -170*65536 followed by 170*65536 -> freq=-1310720.
REQ-035 Bench SHALL drive a step with amplitude=32768 -> freq=0 with squelch=1; the next step, taken at full amplitude, SHALL be measured from the squelched sample's angle.
REQ-036 Bench SHALL drive 17 back-to-back samples stepping +5 deg each -> 16 freq_vaild strobes with freq=327680, and one avg_vaild with avg_freq=327680.
REQ-037 Bench SHALL hold pre_vaild low for 64 cycles, then drive two samples -> the first only primes and the second yields freq_vaild; a 63-cycle gap SHALL keep the FSM in RUN.
REQ-038 Bench SHALL assert rst between the 5th and 6th steps of a frame -> no strobes occur during reset, and the next frame averages only post-reset samples.
